// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared load/store definitions: LIS opcodes, default widths, FSM state
// encoding and small opcode-classification helpers used by the LSU.
package lsu_mem_ctrl_pkg;

  localparam int DEF_LIS_OP_WIDTH   = 3;
  localparam int DEF_MEM_ADDR_WIDTH = 10;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Opcode encoding shared with the load/store formatting stage
  localparam logic [DEF_LIS_OP_WIDTH-1:0] LIS_LB  = 3'd0;
  localparam logic [DEF_LIS_OP_WIDTH-1:0] LIS_LH  = 3'd1;
  localparam logic [DEF_LIS_OP_WIDTH-1:0] LIS_LW  = 3'd2;
  localparam logic [DEF_LIS_OP_WIDTH-1:0] LIS_LBU = 3'd3;
  localparam logic [DEF_LIS_OP_WIDTH-1:0] LIS_LHU = 3'd4;
  localparam logic [DEF_LIS_OP_WIDTH-1:0] LIS_SB  = 3'd5;
  localparam logic [DEF_LIS_OP_WIDTH-1:0] LIS_SH  = 3'd6;
  localparam logic [DEF_LIS_OP_WIDTH-1:0] LIS_SW  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  function automatic logic lis_is_byte(input logic [DEF_LIS_OP_WIDTH-1:0] op);
    return (op == LIS_LB) || (op == LIS_LBU) || (op == LIS_SB);
  endfunction

  function automatic logic lis_is_half(input logic [DEF_LIS_OP_WIDTH-1:0] op);
    return (op == LIS_LH) || (op == LIS_LHU) || (op == LIS_SH);
  endfunction

  function automatic logic lis_is_store(input logic [DEF_LIS_OP_WIDTH-1:0] op);
    return op >= LIS_SB;
  endfunction

endpackage

// File: rtl/lsu_lane_steer.sv
// Combinational byte-lane steering: byte enables, store-data replication and
// the byte shift applied to returned read data, all from opcode and offset.
module lsu_lane_steer
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int LIS_OP_WIDTH = DEF_LIS_OP_WIDTH
) (
  input  logic [LIS_OP_WIDTH-1:0] op,
  input  logic [1:0]              off,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [3:0]              be,
  output logic [DATA_WIDTH-1:0]   lane_wdata,
  output logic [1:0]              rd_shift
);

  // Word access by default; narrower sizes override. Misaligned low bits
  // inside the access size are dropped, so SH@1 acts as SH@0 and SW@n as SW@0.
  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata;
    rd_shift   = 2'd0;
    if (lis_is_byte(op)) begin
      be         = 4'b0001 << off;
      lane_wdata = {4{wdata[7:0]}};
      rd_shift   = off;
    end else if (lis_is_half(op)) begin
      be         = off[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{wdata[15:0]}};
      rd_shift   = {off[1], 1'b0};
    end
    if (!lis_is_store(op)) begin
      lane_wdata = '0;
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Data-memory access controller: one outstanding load/store, req/ack
// handshake with the memory, lane-shifted read return and pipeline stall.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the
// memory and respond immediately with err_o=1.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int LIS_OP_WIDTH   = DEF_LIS_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [LIS_OP_WIDTH-1:0]   lis_op_i,
  input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      rsp_valid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      err_o,
  output logic                      stall_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [MEM_ADDR_WIDTH-3:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_ack_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 16) ? $clog2(TIMEOUT_CYCLES) : 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t                state_q, state_d;
  logic [LIS_OP_WIDTH-1:0]   op_p0;
  logic [MEM_ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0]     wdata_p0;
  logic [CNT_W-1:0]          cnt_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;

  logic                      in_idle, in_wait, in_resp;
  logic                      accept, timeout_hit, trap_mis;
  logic [3:0]                lane_be;
  logic [DATA_WIDTH-1:0]     lane_wdata;
  logic [1:0]                rd_shift;

  assign in_idle     = (state_q == ST_IDLE);
  assign in_wait     = (state_q == ST_WAIT);
  assign in_resp     = (state_q == ST_RESP);
  assign accept      = in_idle && req_valid_i;
  assign timeout_hit = (cnt_q == CNT_LAST);

`ifdef MISALIGN_TRAP_EN
  assign trap_mis = (lis_is_half(lis_op_i) && addr_i[0]) ||
                    (!lis_is_byte(lis_op_i) && !lis_is_half(lis_op_i) &&
                     (addr_i[1:0] != 2'b00));
`else
  assign trap_mis = 1'b0;
`endif

  lsu_lane_steer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LIS_OP_WIDTH (LIS_OP_WIDTH)
  ) u_lane_steer (
    .op         (op_p0),
    .off        (addr_p0[1:0]),
    .wdata      (wdata_p0),
    .be         (lane_be),
    .lane_wdata (lane_wdata),
    .rd_shift   (rd_shift)
  );

  // Memory-side fields are only driven while the request is outstanding,
  // so everything reads zero in IDLE/RESP and immediately on reset.
  assign req_ready_o = in_idle && !rst;
  assign stall_o     = !in_idle;
  assign rsp_valid_o = in_resp;
  assign err_o       = in_resp && err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = in_wait;
  assign mem_we_o    = in_wait && lis_is_store(op_p0);
  assign mem_be_o    = in_wait ? lane_be : 4'b0000;
  assign mem_addr_o  = in_wait ? addr_p0[MEM_ADDR_WIDTH-1:2] : '0;
  assign mem_wdata_o = in_wait ? lane_wdata : '0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: ack beats a simultaneous timeout on the last WAIT cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid_i) state_d = trap_mis ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem_ack_i || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and response data/error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p0    <= '0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_p0    <= lis_op_i;
        addr_p0  <= addr_i;
        wdata_p0 <= wdata_i;
        cnt_q    <= '0;
        if (trap_mis) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end else if (in_wait) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (mem_ack_i) begin
          err_q   <= 1'b0;
          rdata_q <= lis_is_store(op_p0) ? '0 : (mem_rdata_i >> {rd_shift, 3'b000});
        end else if (timeout_hit) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

endmodule
